// File: rtl/ysyx_22050710_sram_responder_pkg.sv
// Shared encodings and the in-flight response entry for the SRAM-like responder.
package ysyx_22050710_sram_responder_pkg;

    localparam int TIMER_WD = 4;

    typedef enum logic [1:0] {
        SIZE_1B = 2'd0,
        SIZE_2B = 2'd1,
        SIZE_4B = 2'd2,
        SIZE_8B = 2'd3
    } size_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef struct packed {
        logic                valid;
        op_e                 op;
        size_e               size;
        logic [TIMER_WD-1:0] timer;
    } resp_ent_t;

endpackage

// File: rtl/ysyx_22050710_sram_resp_fifo.sv
// In-order response queue: each entry counts down its latency, head pops at zero.
module ysyx_22050710_sram_resp_fifo
    import ysyx_22050710_sram_responder_pkg::*;
#(
    parameter  int DEPTH   = 2,
    parameter  int DATA_WD = 64,
    parameter  int LATENCY = 1,
    localparam int PTR_WD  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  op_e                push_op,
    input  size_e              push_size,
    input  logic               cap_en,
    input  logic [PTR_WD-1:0]  cap_idx,
    input  logic [DATA_WD-1:0] cap_data,
    output logic               full,
    output logic               empty,
    output logic               pop,
    output logic [PTR_WD-1:0]  head_ptr,
    output logic [PTR_WD-1:0]  tail_ptr,
    output size_e              head_size,
    output logic [DATA_WD-1:0] head_data
);

    localparam int CNT_WD = $clog2(DEPTH) + 1;

    resp_ent_t          ent_reg  [DEPTH];
    logic [DATA_WD-1:0] data_reg [DEPTH];
    logic [PTR_WD-1:0]  head_reg;
    logic [PTR_WD-1:0]  tail_reg;
    logic [CNT_WD-1:0]  count_reg;

    assign head_ptr  = head_reg;
    assign tail_ptr  = tail_reg;
    assign pop       = ent_reg[head_reg].valid && (ent_reg[head_reg].timer == '0);
    assign full      = (count_reg == CNT_WD'(DEPTH));
    assign empty     = (count_reg == '0);
    assign head_size = ent_reg[head_reg].size;
    assign head_data = data_reg[head_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic push_here;
            logic pop_here;
            assign push_here = push && (tail_reg == PTR_WD'(gi));
            assign pop_here  = pop && (head_reg == PTR_WD'(gi));

            // A full queue may pop and push the same slot; the new request wins.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ent_reg[gi] <= '0;
                end else if (push_here) begin
                    ent_reg[gi] <= '{valid: 1'b1, op: push_op, size: push_size,
                                     timer: TIMER_WD'(LATENCY - 1)};
                end else if (pop_here) begin
                    ent_reg[gi].valid <= 1'b0;
                end else if (ent_reg[gi].valid && (ent_reg[gi].timer != '0)) begin
                    ent_reg[gi].timer <= ent_reg[gi].timer - 1'b1;
                end
            end

            // Writes answer with zero; reads are overwritten by the memory return a cycle later.
            always_ff @(posedge clk) begin
                if (push_here) begin
                    data_reg[gi] <= '0;
                end else if (cap_en && (cap_idx == PTR_WD'(gi))) begin
                    data_reg[gi] <= cap_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= (tail_reg == PTR_WD'(DEPTH - 1)) ? '0 : tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= (head_reg == PTR_WD'(DEPTH - 1)) ? '0 : head_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_22050710_sram_responder.sv
// SRAM-like bus slave: forwards accepted requests to a synchronous memory and
// returns in-order responses after a fixed latency.
module ysyx_22050710_sram_responder
    import ysyx_22050710_sram_responder_pkg::*;
#(
    parameter int SRAM_ADDR_WD    = 32,
    parameter int SRAM_DATA_WD    = 64,
    parameter int SRAM_WMASK_WD   = 8,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req,
    input  logic                     i_op,
    input  logic [1:0]               i_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_wdata,
    output logic                     o_addr_ok,
    output logic                     o_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_rdata,
    output logic                     o_mem_en,
    output logic                     o_mem_we,
    output logic [SRAM_ADDR_WD-1:0]  o_mem_addr,
    output logic [SRAM_WMASK_WD-1:0] o_mem_wmask,
    output logic [SRAM_DATA_WD-1:0]  o_mem_wdata,
    input  logic [SRAM_DATA_WD-1:0]  i_mem_rdata
);

    localparam int OFFS_WD = $clog2(SRAM_WMASK_WD);
    localparam int PTR_WD  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                    ready_reg;
    logic                    fire;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [PTR_WD-1:0]       head_ptr;
    logic [PTR_WD-1:0]       tail_ptr;
    size_e                   head_size;
    logic [SRAM_DATA_WD-1:0] head_data;
    logic                    cap_pending_reg;
    logic [PTR_WD-1:0]       cap_idx_reg;
    logic                    bypass;
    logic [OFFS_WD+2:0]      unused_bits;

    // Size is carried with the entry only; access is always the full aligned word.
    assign unused_bits = {head_size, fifo_empty, i_addr[OFFS_WD-1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
        end
    end

    assign o_addr_ok = ready_reg & (~fifo_full | fifo_pop);
    assign fire      = i_req & o_addr_ok;

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wmask = '0;
        o_mem_wdata = '0;
        if (fire) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_op;
            o_mem_addr  = {i_addr[SRAM_ADDR_WD-1:OFFS_WD], {OFFS_WD{1'b0}}};
            o_mem_wmask = (i_op == OP_WRITE) ? i_wstrb : '0;
            o_mem_wdata = i_wdata;
        end
    end

    // Memory read data arrives one cycle after the fire; remember which slot it belongs to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_pending_reg <= 1'b0;
            cap_idx_reg     <= '0;
        end else begin
            cap_pending_reg <= fire && (i_op == OP_READ);
            cap_idx_reg     <= tail_ptr;
        end
    end

    ysyx_22050710_sram_resp_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .DATA_WD (SRAM_DATA_WD),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (fire),
        .push_op   (op_e'(i_op)),
        .push_size (size_e'(i_size)),
        .cap_en    (cap_pending_reg),
        .cap_idx   (cap_idx_reg),
        .cap_data  (i_mem_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .pop       (fifo_pop),
        .head_ptr  (head_ptr),
        .tail_ptr  (tail_ptr),
        .head_size (head_size),
        .head_data (head_data)
    );

    // With single-cycle latency the head pops in the same cycle its read data returns.
    assign bypass    = (LATENCY == 1) && cap_pending_reg && (cap_idx_reg == head_ptr);
    assign o_data_ok = fifo_pop;

    always_comb begin
        o_rdata = '0;
        if (fifo_pop) begin
            o_rdata = bypass ? i_mem_rdata : head_data;
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_sram_responder.sv
// Bench: two responders (LATENCY 1 and 3, depth 2) with memory models and a response scoreboard.
module tb_ysyx_22050710_sram_responder;

    localparam int N = 2;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fails  = 0;

    logic [N-1:0]       req, op, addr_ok, data_ok, mem_en, mem_we;
    logic [N-1:0][1:0]  size;
    logic [N-1:0][31:0] addr, mem_addr;
    logic [N-1:0][7:0]  wstrb, mem_wmask;
    logic [N-1:0][63:0] wdata, rdata, mem_wdata, mem_rdata;

    logic [63:0] mem     [N][16];
    logic [63:0] exp_mem [N][16];
    bit          mem_loaded = 1'b0;
    exp_t        sb_q [N][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_word(input int i);
        return 64'h1122_3344_5566_7788 ^ {8{8'(i)}};
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        ysyx_22050710_sram_responder #(
            .SRAM_ADDR_WD    (32),
            .SRAM_DATA_WD    (64),
            .SRAM_WMASK_WD   (8),
            .LATENCY         ((gi == 0) ? 1 : 3),
            .MAX_OUTSTANDING (2)
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_req       (req[gi]),
            .i_op        (op[gi]),
            .i_size      (size[gi]),
            .i_addr      (addr[gi]),
            .i_wstrb     (wstrb[gi]),
            .i_wdata     (wdata[gi]),
            .o_addr_ok   (addr_ok[gi]),
            .o_data_ok   (data_ok[gi]),
            .o_rdata     (rdata[gi]),
            .o_mem_en    (mem_en[gi]),
            .o_mem_we    (mem_we[gi]),
            .o_mem_addr  (mem_addr[gi]),
            .o_mem_wmask (mem_wmask[gi]),
            .o_mem_wdata (mem_wdata[gi]),
            .i_mem_rdata (mem_rdata[gi])
        );
    end

    // Single-port synchronous memory per DUT, read data registered.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int d = 0; d < N; d++)
                for (int i = 0; i < 16; i++) mem[d][i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            for (int d = 0; d < N; d++) begin
                if (mem_en[d]) begin
                    for (int b = 0; b < 8; b++)
                        if (mem_we[d] && mem_wmask[d][b])
                            mem[d][mem_addr[d][6:3]][b*8 +: 8] <= mem_wdata[d][b*8 +: 8];
                    mem_rdata[d] <= mem[d][mem_addr[d][6:3]];
                end
            end
        end
    end

    task automatic drive(input int d, input logic r, input logic o, input logic [31:0] a,
                         input logic [7:0] s, input logic [63:0] wd);
        req[d] = r; op[d] = o; addr[d] = a; wstrb[d] = s; wdata[d] = wd; size[d] = 2'd3;
    endtask

    // Scoreboard: pushes on every fire, pops and compares on every data_ok.
    task automatic monitor(input int d);
        exp_t e;
        int   idx;
        forever begin
            @(negedge clk);
            if (!rst_n) sb_q[d].delete();
            if (data_ok[d]) begin
                n_checks++;
                if (sb_q[d].size() == 0) begin
                    n_fails++;
                    $display("FAIL spurious_data_ok dut%0d cyc %0d: got data_ok=1 rdata=%h, required no response", d, cyc, rdata[d]);
                end else begin
                    e = sb_q[d].pop_front();
                    if (e.due != cyc || rdata[d] !== e.data) begin
                        n_fails++;
                        $display("FAIL resp dut%0d: got cyc %0d rdata=%h, required cyc %0d rdata=%h", d, cyc, rdata[d], e.due, e.data);
                    end else begin
                        $display("dut%0d resp cyc %0d rdata=%h", d, cyc, rdata[d]);
                    end
                end
            end else if (sb_q[d].size() != 0) begin
                n_checks++;
                if (sb_q[d][0].due < cyc) begin
                    n_fails++;
                    $display("FAIL missing_data_ok dut%0d cyc %0d: got no response, required one at cyc %0d", d, cyc, sb_q[d][0].due);
                    void'(sb_q[d].pop_front());
                end
            end
            if (rst_n && req[d] && addr_ok[d]) begin
                idx = int'(addr[d][6:3]);
                n_checks++;
                if (mem_en[d] !== 1'b1 || mem_we[d] !== op[d] || mem_addr[d] !== {addr[d][31:3], 3'b000}
                    || mem_wmask[d] !== (op[d] ? wstrb[d] : 8'h00) || mem_wdata[d] !== wdata[d]) begin
                    n_fails++;
                    $display("FAIL mem_port dut%0d cyc %0d: got en=%b we=%b addr=%h mask=%h, required en=1 we=%b addr=%h mask=%h",
                             d, cyc, mem_en[d], mem_we[d], mem_addr[d], mem_wmask[d], op[d],
                             {addr[d][31:3], 3'b000}, op[d] ? wstrb[d] : 8'h00);
                end
                e.due  = cyc + lat_of(d);
                e.data = op[d] ? 64'h0 : exp_mem[d][idx];
                sb_q[d].push_back(e);
                if (op[d])
                    for (int b = 0; b < 8; b++)
                        if (wstrb[d][b]) exp_mem[d][idx][b*8 +: 8] = wdata[d][b*8 +: 8];
            end else begin
                n_checks++;
                if (mem_en[d] !== 1'b0) begin
                    n_fails++;
                    $display("FAIL idle_mem_en dut%0d cyc %0d: got mem_en=%b, required 0", d, cyc, mem_en[d]);
                end
            end
        end
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 1'b0, 32'h8000_0000, 8'h00, 64'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if ({addr_ok[d], data_ok[d], mem_en[d], mem_we[d]} !== 4'b0000 || rdata[d] !== 64'h0
                || mem_addr[d] !== 32'h0 || mem_wmask[d] !== 8'h0 || mem_wdata[d] !== 64'h0) begin
                n_fails++;
                $display("FAIL reset_outputs dut%0d: got addr_ok=%b data_ok=%b mem_en=%b rdata=%h, required all 0",
                         d, addr_ok[d], data_ok[d], mem_en[d], rdata[d]);
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (addr_ok[d] !== 1'b0) begin
                n_fails++;
                $display("FAIL release_addr_ok dut%0d: got %b, required 0", d, addr_ok[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (addr_ok[d] !== 1'b1) begin
                n_fails++;
                $display("FAIL ready_addr_ok dut%0d: got %b, required 1", d, addr_ok[d]);
            end
        end
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h8000_0004, 8'h00, 64'h0);
        @(negedge clk);
        n_checks++;
        if (addr_ok[0] !== 1'b1 || mem_addr[0] !== 32'h8000_0000) begin
            n_fails++;
            $display("FAIL single_read_issue: got addr_ok=%b mem_addr=%h, required 1 80000000", addr_ok[0], mem_addr[0]);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        @(negedge clk);
        n_checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 64'h1122_3344_5566_7788) begin
            n_fails++;
            $display("FAIL single_read_resp: got data_ok=%b rdata=%h, required 1 1122334455667788", data_ok[0], rdata[0]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b0, 32'h8000_0000 + 32'(i * 8), 8'h00, 64'h0);
            @(negedge clk);
            n_checks++;
            if (addr_ok[0] !== 1'b1) begin
                n_fails++;
                $display("FAIL b2b_addr_ok req %0d: got %b, required 1", i, addr_ok[0]);
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_throughput();
        int exp_pat [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
        int fired = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            drive(1, 1'b1, 1'b0, 32'h8000_0000 + 32'((fired + 5) * 8), 8'h00, 64'h0);
            @(negedge clk);
            n_checks++;
            if (addr_ok[1] !== 1'(exp_pat[c])) begin
                n_fails++;
                $display("FAIL throughput_addr_ok cycle %0d: got %b, required %0d", c, addr_ok[1], exp_pat[c]);
            end
            if (addr_ok[1]) fired++;
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        n_checks++;
        if (fired != 6) begin
            n_fails++;
            $display("FAIL throughput_fires: got %0d, required 6", fired);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_write_read(input int d);
        logic [63:0] old_w = init_word(2);
        logic [63:0] want = {old_w[63:32], 32'hBBBB_BBBB};
        int got = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0)      drive(d, 1'b1, 1'b1, 32'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
            else if (c == 1) drive(d, 1'b1, 1'b0, 32'h8000_0014, 8'h00, 64'h0);
            else             drive(d, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
            @(negedge clk);
            if (c < 2) begin
                n_checks++;
                if (addr_ok[d] !== 1'b1) begin
                    n_fails++;
                    $display("FAIL wr_rd_addr_ok dut%0d step %0d: got %b, required 1", d, c, addr_ok[d]);
                end
            end
            if (data_ok[d]) begin
                got++;
                n_checks++;
                if (got == 1 && rdata[d] !== 64'h0) begin
                    n_fails++;
                    $display("FAIL write_resp dut%0d: got rdata=%h, required 0", d, rdata[d]);
                end else if (got == 2 && rdata[d] !== want) begin
                    n_fails++;
                    $display("FAIL read_after_write dut%0d: got rdata=%h, required %h", d, rdata[d], want);
                end
            end
        end
        n_checks++;
        if (got != 2) begin
            n_fails++;
            $display("FAIL wr_rd_responses dut%0d: got %0d, required 2", d, got);
        end
    endtask

    task automatic test_reset_midflight();
        int stray = 0;
        int got = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            drive(1, 1'b1, 1'b0, 32'h8000_0000 + 32'((12 + c) * 8), 8'h00, 64'h0);
            @(negedge clk);
            n_checks++;
            if (addr_ok[1] !== 1'b1) begin
                n_fails++;
                $display("FAIL midflight_issue %0d: got addr_ok=%b, required 1", c, addr_ok[1]);
            end
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (addr_ok[1] !== 1'b0 || data_ok[1] !== 1'b0) begin
            n_fails++;
            $display("FAIL midflight_in_reset: got addr_ok=%b data_ok=%b, required 0 0", addr_ok[1], data_ok[1]);
        end
        #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (data_ok[1]) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fails++;
            $display("FAIL midflight_dropped: got %0d data_ok pulses, required 0", stray);
        end
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h8000_0060, 8'h00, 64'h0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        for (int c = 0; c < 8 && got == 0; c++) begin
            @(negedge clk);
            if (data_ok[1]) begin
                got = 1;
                n_checks++;
                if (rdata[1] !== init_word(12)) begin
                    n_fails++;
                    $display("FAIL post_reset_read: got rdata=%h, required %h", rdata[1], init_word(12));
                end
            end
        end
        if (got == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL post_reset_read: got no data_ok within 8 cycles, required one");
        end
    endtask

    initial begin
        for (int d = 0; d < N; d++)
            for (int i = 0; i < 16; i++) exp_mem[d][i] = init_word(i);
        fork
            monitor(0);
            monitor(1);
        join_none
        test_reset();
        test_single_read();
        test_back_to_back();
        test_throughput();
        test_write_read(0);
        test_write_read(1);
        test_reset_midflight();
        repeat (6) @(negedge clk);
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (sb_q[d].size() != 0) begin
                n_fails++;
                $display("FAIL scoreboard_drained dut%0d: got %0d pending, required 0", d, sb_q[d].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
